// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between IF fetch and a debug/loader port,
// and owns the IF/ID instruction output. Starvation guard enabled by IMEM_ARB_STARVE_GUARD_EN.
module imem_port_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_stall,
  input  logic              if_flush,
  input  logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              if_hold,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic        fetch_want;
  logic        fetch_gnt;
  logic        dbg_gnt;
  logic        fetch_q;
  logic        flush_q;
  logic        dbg_rd_q;
  logic        stolen_q;
  logic [31:0] instr_hold;
  logic        unused_pc;

  assign unused_pc = ^{if_pc[31:ADDR_W+2], if_pc[1:0]};

`ifdef IMEM_ARB_STARVE_GUARD_EN
  typedef enum logic [1:0] {ARB, HOLD, STEAL} state_t;
  state_t     state;
  state_t     state_next;
  logic [7:0] starve_cnt;
  logic       steal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB:     if (starve_cnt >= 8'(STARVE_LIMIT)) state_next = HOLD;
      HOLD:    state_next = dbg_gnt ? ARB : STEAL;
      STEAL:   state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_comb begin
    steal   = (state == STEAL);
    if_hold = (state != ARB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      stolen_q   <= 1'b0;
    end else begin
      stolen_q <= steal;
      if (!dbg_req || dbg_ready)  starve_cnt <= '0;
      else if (starve_cnt != '1)  starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign fetch_want = !if_stall && !if_flush && !steal;
`else
  assign if_hold    = 1'b0;
  assign stolen_q   = 1'b0;
  assign fetch_want = !if_stall && !if_flush;
`endif

  // Grants are gated by reset so a pending access is dropped the instant reset asserts.
  always_comb begin
    fetch_gnt = 1'b0;
    dbg_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = if_pc[ADDR_W+1:2];
    mem_wdata = '0;
    if (reset) begin
      if (fetch_want) begin
        fetch_gnt = 1'b1;
        mem_en    = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt   = 1'b1;
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
    end
  end

  assign dbg_ready  = dbg_gnt;
  assign dbg_rvalid = dbg_rd_q;
  assign dbg_rdata  = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_q    <= 1'b0;
      flush_q    <= 1'b0;
      dbg_rd_q   <= 1'b0;
      instr_hold <= '0;
    end else begin
      fetch_q    <= fetch_gnt;
      flush_q    <= if_flush && !if_stall;
      dbg_rd_q   <= dbg_gnt && !dbg_we;
      instr_hold <= if_instr;
    end
  end

  always_comb begin
    if (fetch_q)                  if_instr = mem_rdata;
    else if (flush_q || stolen_q) if_instr = '0;
    else                          if_instr = instr_hold;
  end

endmodule
